// File: rtl/ppa_pkg.sv
// Shared definitions for the ppa prefix-adder family: default word geometry
// and the packet FSM state encoding used by the streaming subtractor.
package ppa_pkg;

  localparam int SUB_W         = 8;
  localparam int SUB_MAX_WORDS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sub_state_e;

endpackage

// File: rtl/ppa_sk_cin.sv
// W-bit Sklansky parallel-prefix adder with carry-in and carry-out.
// The carry-in is absorbed into the bit-0 generate term, so every prefix G is a true carry.
module ppa_sk_cin #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  localparam int LV = (W > 1) ? $clog2(W) : 1;

  // Half-adder stage: per-bit propagate and generate.
  wire [W-1:0] p0 = a_i ^ b_i;
  wire [W-1:0] g0 = a_i & b_i;

  wire [W-1:0] g_l [0:LV];
  wire [W-1:0] p_l [0:LV-1];

  assign g_l[0][0] = g0[0] | (p0[0] & cin_i);
  assign p_l[0]    = p0;

  for (genvar i = 1; i < W; i++) begin : g_init
    assign g_l[0][i] = g0[i];
  end

  // Bit i joins the group ending just below its lv-aligned block; P is not
  // carried into the final level because every group there already reaches bit 0.
  for (genvar lv = 0; lv < LV; lv++) begin : g_lvl
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (((i >> lv) & 1) == 1) begin : g_cell
        localparam int J = ((i >> lv) << lv) - 1;
        assign g_l[lv+1][i] = g_l[lv][i] | (p_l[lv][i] & g_l[lv][J]);
        if (lv < LV - 1) begin : g_black
          assign p_l[lv+1][i] = p_l[lv][i] & p_l[lv][J];
        end
      end else begin : g_pass
        assign g_l[lv+1][i] = g_l[lv][i];
        if (lv < LV - 1) begin : g_ppass
          assign p_l[lv+1][i] = p_l[lv][i];
        end
      end
    end
  end

  assign s_o[0] = p0[0] ^ cin_i;
  for (genvar i = 1; i < W; i++) begin : g_sum
    assign s_o[i] = p0[i] ^ g_l[LV][i-1];
  end

  assign cout_o = g_l[LV][W-1];

endmodule

// File: rtl/ppa_sub_stream.sv
// Word-serial wide-operand subtractor D = A - B, LSW first, borrow carried between
// words; reports borrow (A < B) and equality on the final word of each packet.
module ppa_sub_stream
  import ppa_pkg::*;
#(
  parameter int W         = SUB_W,
  parameter int MAX_WORDS = SUB_MAX_WORDS,
  parameter int CW        = $clog2(MAX_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_d,
  output logic [CW-1:0] out_idx,
  output logic          out_last,
  output logic          out_borrow,
  output logic          out_zero,
  output logic          err_len
);

  sub_state_e    state_q, state_d;
  logic          borrow_q, borrow_d;
  logic          zero_q, zero_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic          ov_q, ov_d;
  logic [W-1:0]  od_q, od_d;
  logic [CW-1:0] oidx_q, oidx_d;
  logic          olast_q, olast_d;
  logic          oborrow_q, oborrow_d;
  logic          ozero_q, ozero_d;

  logic          xfer;
  logic          cin;
  logic [W-1:0]  diff;
  logic          cout;
  logic          at_max;
  logic          overlen;
  logic          word_last;
  logic          borrow_nx;
  logic          zero_nx;

  // One-deep output register: ready depends only on registered state and out_ready.
  assign in_ready = !ov_q | out_ready;
  assign xfer     = in_valid & in_ready;

  // A packet's first word always subtracts with no incoming borrow.
  assign cin = (state_q == IDLE) | !borrow_q;

  ppa_sk_cin #(.W(W)) u_add (
    .a_i    (in_a),
    .b_i    (~in_b),
    .cin_i  (cin),
    .s_o    (diff),
    .cout_o (cout)
  );

  assign at_max    = (idx_q == CW'(MAX_WORDS - 1));
  assign overlen   = at_max & !in_last;
  assign word_last = in_last | at_max;
  assign borrow_nx = !cout;
  assign zero_nx   = zero_q & (diff == '0);

  // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    borrow_d  = borrow_q;
    zero_d    = zero_q;
    idx_d     = idx_q;
    err_d     = err_q;
    ov_d      = ov_q & !out_ready;
    od_d      = od_q;
    oidx_d    = oidx_q;
    olast_d   = olast_q;
    oborrow_d = oborrow_q;
    ozero_d   = ozero_q;

    if (xfer) begin
      ov_d      = 1'b1;
      od_d      = diff;
      oidx_d    = idx_q;
      olast_d   = word_last;
      oborrow_d = word_last & borrow_nx;
      ozero_d   = word_last & zero_nx;
      if (overlen) begin
        err_d = 1'b1;
      end
      if (word_last) begin
        state_d  = IDLE;
        borrow_d = 1'b0;
        zero_d   = 1'b1;
        idx_d    = '0;
      end else begin
        state_d  = BUSY;
        borrow_d = borrow_nx;
        zero_d   = zero_nx;
        idx_d    = idx_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      borrow_q  <= 1'b0;
      zero_q    <= 1'b1;
      idx_q     <= '0;
      err_q     <= 1'b0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      oidx_q    <= '0;
      olast_q   <= 1'b0;
      oborrow_q <= 1'b0;
      ozero_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      borrow_q  <= borrow_d;
      zero_q    <= zero_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      oidx_q    <= oidx_d;
      olast_q   <= olast_d;
      oborrow_q <= oborrow_d;
      ozero_q   <= ozero_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_d      = od_q;
  assign out_idx    = oidx_q;
  assign out_last   = olast_q;
  assign out_borrow = oborrow_q;
  assign out_zero   = ozero_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_ppa_sub_stream.sv
// Scoreboard bench for ppa_sub_stream: packets are modelled as whole integers
// (D = A - B mod 2^(8n)), expected words are queued and a monitor pops them.
module tb_ppa_sub_stream;

  localparam int W    = 8;
  localparam int MAXW = 4;
  localparam int CW   = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_d;
  logic [CW-1:0] out_idx;
  logic          out_last;
  logic          out_borrow;
  logic          out_zero;
  logic          err_len;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
  } word_t;

  typedef struct {
    logic [7:0] d;
    int         idx;
    logic       last;
    logic       borrow;
    logic       zero;
    logic       err;
  } exp_t;

  word_t stim_q[$];
  exp_t  sb_q[$];
  int    total     = 0;
  int    bad       = 0;
  int    rdy_mode  = 0;
  int    rdy_phase = 0;
  bit    err_model = 1'b0;
  bit    gap_en    = 1'b0;

  ppa_sub_stream #(.W(W), .MAX_WORDS(MAXW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .err_len    (err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random, 3 = never.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
          rdy_phase++;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one packet as plain integers.
  task automatic model_packet(input int first, input int n, input bit by_len);
    longint a_v = 0;
    longint b_v = 0;
    longint modv;
    longint d_v;
    exp_t   e;
    for (int k = 0; k < n; k++) begin
      a_v = a_v | (longint'(stim_q[first + k].a) << (8 * k));
      b_v = b_v | (longint'(stim_q[first + k].b) << (8 * k));
    end
    modv = longint'(1) << (8 * n);
    d_v  = (a_v - b_v + modv) % modv;
    for (int k = 0; k < n; k++) begin
      e.d      = 8'(d_v >> (8 * k));
      e.idx    = k;
      e.last   = (k == n - 1);
      e.borrow = e.last && (a_v < b_v);
      e.zero   = e.last && (a_v == b_v);
      if (e.last && by_len) err_model = 1'b1;
      e.err    = err_model;
      sb_q.push_back(e);
    end
  endtask

  task automatic add_word(input logic [7:0] a, input logic [7:0] b, input logic last);
    word_t w;
    w.a = a;
    w.b = b;
    w.last = last;
    stim_q.push_back(w);
  endtask

  // Called at a falling edge; returns at a falling edge after the word transferred.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic last);
    int waited = 0;
    bit sent   = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!sent && waited < 200) begin
      sent = in_ready;
      @(negedge clk);
      waited++;
    end
    if (sent) begin
      check("latency_out_valid", 32'(out_valid), 32'd1);
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required 1");
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
    if (gap_en && $urandom_range(0, 2) == 0) @(negedge clk);
  endtask

  task automatic run_stream();
    int start = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (stim_q[i].last || (i - start + 1) == MAXW) begin
        model_packet(start, i - start + 1, !stim_q[i].last);
        start = i + 1;
      end
    end
    for (int i = 0; i < stim_q.size(); i++) begin
      send_word(stim_q[i].a, stim_q[i].b, stim_q[i].last);
    end
    stim_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drained_pending", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic rand_packet(input int len);
    bit eq = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < len; k++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = eq ? a : 8'($urandom_range(0, 255));
      add_word(a, b, k == len - 1);
    end
  endtask

  // Monitor: compares on every output transfer and checks stall stability.
  initial begin : monitor
    logic [7:0]    held_d;
    logic [CW-1:0] held_idx;
    bit            prev_stall;
    exp_t          e;
    prev_stall = 1'b0;
    held_d     = '0;
    held_idx   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", 32'(out_valid), 32'd1);
          check("stall_hold_d", 32'(out_d), 32'(held_d));
          check("stall_hold_idx", 32'(out_idx), 32'(held_idx));
        end
        prev_stall = 1'b0;
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          prev_stall = 1'b1;
          held_d     = out_d;
          held_idx   = out_idx;
        end else if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got d=%0h idx=%0d, required no output", out_d, out_idx);
          end else begin
            e = sb_q.pop_front();
            check("out_d", 32'(out_d), 32'(e.d));
            check("out_idx", 32'(out_idx), 32'(e.idx));
            check("out_last", 32'(out_last), 32'(e.last));
            check("out_borrow", 32'(out_borrow), 32'(e.borrow));
            check("out_zero", 32'(out_zero), 32'(e.zero));
            check("err_len", 32'(err_len), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_d", 32'(out_d), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_flags", {29'd0, out_last, out_borrow, out_zero}, 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // A = 0x0100, B = 0x0001
    add_word(8'h00, 8'h01, 1'b0);
    add_word(8'h01, 8'h00, 1'b1);
    run_stream();
    drain();

    // A = B = 0x1234
    add_word(8'h34, 8'h34, 1'b0);
    add_word(8'h12, 8'h12, 1'b1);
    run_stream();
    drain();

    // Underflow then a single-word packet back to back: borrow must reinitialise.
    add_word(8'h01, 8'h02, 1'b0);
    add_word(8'h00, 8'h00, 1'b1);
    add_word(8'h05, 8'h03, 1'b1);
    run_stream();
    drain();

    // Backpressure with 1,0,0,1 ready pattern on random 4-word packets.
    rdy_mode = 1;
    repeat (6) rand_packet(4);
    run_stream();
    drain();

    // Overlength: five words without in_last, then close the second packet.
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) add_word(8'(8'h10 + k), 8'(8'h20 - k), 1'b0);
    add_word(8'h00, 8'h00, 1'b1);
    run_stream();
    drain();
    check("err_len_sticky", 32'(err_len), 32'd1);

    // Random lengths, random ready, random input bubbles.
    rdy_mode = 2;
    gap_en   = 1'b1;
    repeat (20) rand_packet(int'($urandom_range(1, MAXW)));
    run_stream();
    drain();
    check("err_len_still_set", 32'(err_len), 32'd1);

    // Reset in the middle of a packet with a pending output word.
    gap_en   = 1'b0;
    rdy_mode = 3;
    @(negedge clk);
    @(negedge clk);
    send_word(8'h11, 8'h22, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_d", 32'(out_d), 32'd0);
    check("midrst_out_idx", 32'(out_idx), 32'd0);
    check("midrst_flags", {29'd0, out_last, out_borrow, out_zero}, 32'd0);
    check("midrst_err_len", 32'(err_len), 32'd0);
    sb_q.delete();
    err_model = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    add_word(8'h00, 8'h01, 1'b1);
    run_stream();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppa_sub_stream.md
Name: ppa_sub_stream

Overview:
- Word-serial wide-operand subtractor for the hash/KEM datapath. Computes D = A - B over multi-word operands streamed least-significant word first.
- Emits one difference word per accepted input pair and carries the borrow between words in a register.
- On the last word it also reports the borrow (A < B) and equality (A == B) flags.
- Each word is computed by a W-bit parallel-prefix adder with carry-in: D = A + ~B + cin. It is the reverse-direction counterpart of the team's prefix adders, used for modular reduction and compare steps.

Parameters:
- W, 8, word width in bits.
- MAX_WORDS, 4, maximum words per operand packet.
- CW, $clog2(MAX_WORDS), width of the word-index counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word pair valid.
- in_ready  out  1  block can accept an input pair.
- in_a  in  W  minuend word.
- in_b  in  W  subtrahend word.
- in_last  in  1  marks the most-significant word of the packet.
- out_valid  out  1  difference word valid.
- out_ready  in  1  downstream accepts the difference word.
- out_d  out  W  difference word.
- out_idx  out  CW  word index of out_d within its packet, 0 = LSW.
- out_last  out  1  out_d is the final word of its packet.
- out_borrow  out  1  final borrow (A < B); valid only when out_last = 1, else 0.
- out_zero  out  1  all difference words of the packet are zero (A == B); valid only when out_last = 1, else 0.
- err_len  out  1  sticky; set when a packet exceeds MAX_WORDS.

Behaviour:
- Reset (async assert, sync release): all outputs 0, borrow_q = 0, zero_q = 1, idx_q = 0, err_len = 0, state = IDLE.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = !out_valid | out_ready. This is a one-deep output register and must have no combinational path from in_valid to in_ready.
  - out_* holds stable while out_valid & !out_ready.
- Latency: 1 cycle from input transfer to out_valid. Full throughput of one word per cycle when out_ready stays high.
- Per-word arithmetic:
  - {cout, s} = in_a + ~in_b + !borrow_q, at W+1 bits.
  - out_d = s; borrow_next = !cout.
  - zero_next = zero_q & (s == 0).
- FSM:
  - IDLE: borrow_q = 0, zero_q = 1, idx_q = 0. An input transfer with in_last = 0 moves to BUSY. An input transfer with in_last = 1 completes a one-word packet and stays in IDLE.
  - BUSY: each transfer advances idx_q. A transfer with in_last = 1 returns to IDLE and reinitialises borrow_q, zero_q and idx_q for the next packet. A new packet may start in the cycle immediately after the last word, with no bubble.
- Last word: out_last = 1, out_borrow = borrow_next, out_zero = zero_next. On non-last words, out_borrow = out_zero = 0.
- Length error: if a transfer occurs with idx_q = MAX_WORDS-1 and in_last = 0:
  - The word is emitted normally but is treated as last: out_last = 1, flags are reported, FSM returns to IDLE.
  - err_len sets and remains set until reset.
  - Subsequent words belong to a new packet.
- Wrap: idx_q never exceeds MAX_WORDS-1.
- Simultaneous output drain and input accept in the same cycle: the output register loads the new word and out_valid stays 1.
- Reset mid-packet: the partial packet is discarded, the pending output is dropped (out_valid = 0) and state = IDLE. The first post-reset word is idx 0 with borrow-in 0.
- No X on outputs when in_valid = 0. in_a and in_b are ignored unless a transfer occurs.

Decomposition:
- Shared package ppa_pkg: SUB_W default, MAX_WORDS default, and a state enum typedef {IDLE, BUSY}.
- Sub-module ppa_sk_cin: a W-bit Sklansky prefix adder with carry-in and carry-out, built from the existing half-adder and black/grey cell primitives. Carry-in is folded into bit 0 as a generate term. It is instantiated once, with b inverted outside.
- Everything else (FSM, borrow/zero/index registers, output register) stays in ppa_sub_stream.

Test Plan:
- Two-word packet, A = 0x0100, B = 0x0001, out_ready held at 1:
  - out_d = 0xFF (idx 0), then 0x00 (idx 1, last), with out_borrow = 0 and out_zero = 0.
  - Latency is 1 cycle per word.
- Equality, A = B = 0x1234 over two words: out_d = 0x34-0x34 = 0x00, then 0x00, with out_last = 1, out_zero = 1, out_borrow = 0.
- Underflow, A = 0x0001, B = 0x0002: out_d = 0xFF, 0xFF, with out_borrow = 1 and out_zero = 0. The next packet A = 0x05, B = 0x03 (single word) gives out_d = 0x02 with borrow 0, proving borrow reinit.
- Backpressure: a 4-word packet with out_ready toggling 1,0,0,1,… Check in_ready = 0 whenever out_valid & !out_ready, that out_d is stable while stalled, that no word is lost or duplicated, and that results match the golden model for random A/B.
- Overlength: MAX_WORDS = 4, five words sent with in_last = 0 on all of them:
  - The 4th output has out_last = 1 and err_len = 1.
  - The 5th word is emitted as idx 0 of a new packet with borrow-in 0.
  - err_len stays 1.
- Reset mid-packet: assert rst_n = 0 after word 1 of 3. All outputs go to 0 immediately. After release, the packet A = 0x00, B = 0x01 gives out_d = 0xFF, idx 0, last, borrow 1.
